// File: rtl/onchip_ram_pkg.sv
// rtl/onchip_ram_pkg.sv - shared constants and helpers for the dual-port on-chip RAM
package onchip_ram_pkg;

  // Legal read pipeline depths: 1 (registered array read) or 2 (extra output stage)
  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 2;

  // Number of byte lanes for a given data width
  function automatic int be_w(input int data_w);
    return data_w / 8;
  endfunction

  // Even-parity bit for one byte: stored bit makes the 9-bit total even
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/onchip_ram_rdpipe.sv
// rtl/onchip_ram_rdpipe.sv - per-port read valid/data pipeline that holds while disabled
module onchip_ram_rdpipe
  import onchip_ram_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic [READ_LAT-1:0] vld_q;
  logic [DATA_W-1:0]   dat_q [READ_LAT];

  // Shift tokens one stage per enabled cycle; reset discards anything in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < READ_LAT; i++) dat_q[i] <= '0;
    end else if (en) begin
      vld_q[0] <= in_valid;
      dat_q[0] <= in_data;
      for (int i = 1; i < READ_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  // A held token is hidden while disabled and shows again once enable returns
  assign out_valid = vld_q[READ_LAT-1] & en;
  assign out_data  = dat_q[READ_LAT-1];

endmodule

// File: rtl/onchip_ram_dp.sv
// rtl/onchip_ram_dp.sv - true dual-port on-chip RAM, two Avalon-MM slaves; ONCHIP_RAM_PARITY_EN adds per-byte parity
module onchip_ram_dp
  import onchip_ram_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 10000,
  parameter int ADDR_W   = 14,
  parameter int READ_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reset_req,
  input  logic                  clken,
  input  logic                  s1_chipselect,
  input  logic                  s1_read,
  input  logic                  s1_write,
  input  logic [ADDR_W-1:0]     s1_address,
  input  logic [DATA_W/8-1:0]   s1_byteenable,
  input  logic [DATA_W-1:0]     s1_writedata,
  output logic [DATA_W-1:0]     s1_readdata,
  output logic                  s1_readdatavalid,
  input  logic                  s2_chipselect,
  input  logic                  s2_read,
  input  logic                  s2_write,
  input  logic [ADDR_W-1:0]     s2_address,
  input  logic [DATA_W/8-1:0]   s2_byteenable,
  input  logic [DATA_W-1:0]     s2_writedata,
  output logic [DATA_W-1:0]     s2_readdata,
  output logic                  s2_readdatavalid,
  output logic                  addr_err,
  output logic                  par_err,
  input  logic                  err_clr
);

  localparam int BE_W = be_w(DATA_W);

  if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX) begin : g_bad_read_lat
    $error("onchip_ram_dp: READ_LAT must be 1 or 2");
  end
  if ((64'd1 << ADDR_W) < 64'(DEPTH)) begin : g_bad_addr_w
    $error("onchip_ram_dp: ADDR_W too narrow for DEPTH");
  end
  if ((DATA_W % 8) != 0 || DATA_W < 8 || DATA_W > 128) begin : g_bad_data_w
    $error("onchip_ram_dp: DATA_W must be a multiple of 8 in 8..128");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  logic en;
  logic s1_in_range, s2_in_range;
  logic s1_wr_ok, s2_wr_ok;
  logic s1_rd_acc, s2_rd_acc;
  logic s1_oor, s2_oor;
  logic [DATA_W-1:0] s1_rd_word, s2_rd_word;

  assign en = clken & ~reset_req;

  assign s1_in_range = 32'(s1_address) < DEPTH;
  assign s2_in_range = 32'(s2_address) < DEPTH;

  // Write wins over read on the same port, so a read is accepted only without write
  assign s1_wr_ok  = en & s1_chipselect & s1_write & s1_in_range;
  assign s2_wr_ok  = en & s2_chipselect & s2_write & s2_in_range;
  assign s1_rd_acc = en & s1_chipselect & s1_read & ~s1_write;
  assign s2_rd_acc = en & s2_chipselect & s2_read & ~s2_write;

  assign s1_oor = en & s1_chipselect & (s1_read | s1_write) & ~s1_in_range;
  assign s2_oor = en & s2_chipselect & (s2_read | s2_write) & ~s2_in_range;

  // Array is read before this edge's writes land, so a cross-port read sees old data
  assign s1_rd_word = (s1_rd_acc && s1_in_range) ? mem[s1_address] : '0;
  assign s2_rd_word = (s2_rd_acc && s2_in_range) ? mem[s2_address] : '0;

  // Lane-merged writes: s1 is applied last so it owns lanes both ports enable
  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (s2_wr_ok && s2_byteenable[i]) mem[s2_address][i*8 +: 8] <= s2_writedata[i*8 +: 8];
      if (s1_wr_ok && s1_byteenable[i]) mem[s1_address][i*8 +: 8] <= s1_writedata[i*8 +: 8];
    end
  end

  onchip_ram_rdpipe #(.DATA_W(DATA_W), .READ_LAT(READ_LAT)) u_rdpipe_s1 (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .in_valid  (s1_rd_acc),
    .in_data   (s1_rd_word),
    .out_valid (s1_readdatavalid),
    .out_data  (s1_readdata)
  );

  onchip_ram_rdpipe #(.DATA_W(DATA_W), .READ_LAT(READ_LAT)) u_rdpipe_s2 (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .in_valid  (s2_rd_acc),
    .in_data   (s2_rd_word),
    .out_valid (s2_readdatavalid),
    .out_data  (s2_readdata)
  );

  // Sticky range-error flag; a new error beats a simultaneous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 addr_err <= 1'b0;
    else if (s1_oor || s2_oor) addr_err <= 1'b1;
    else if (en && err_clr)    addr_err <= 1'b0;
  end

`ifdef ONCHIP_RAM_PARITY_EN
  logic [BE_W-1:0] par_mem [DEPTH];
  logic s1_par_bad, s2_par_bad;

  // Parity bits follow the same lane merge as the data array
  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (s2_wr_ok && s2_byteenable[i]) par_mem[s2_address][i] <= byte_parity(s2_writedata[i*8 +: 8]);
      if (s1_wr_ok && s1_byteenable[i]) par_mem[s1_address][i] <= byte_parity(s1_writedata[i*8 +: 8]);
    end
  end

  // Check every lane of an in-range read; zero data from out-of-range reads is never checked
  always_comb begin
    s1_par_bad = 1'b0;
    s2_par_bad = 1'b0;
    for (int i = 0; i < BE_W; i++) begin
      if (s1_rd_acc && s1_in_range && (byte_parity(s1_rd_word[i*8 +: 8]) != par_mem[s1_address][i]))
        s1_par_bad = 1'b1;
      if (s2_rd_acc && s2_in_range && (byte_parity(s2_rd_word[i*8 +: 8]) != par_mem[s2_address][i]))
        s2_par_bad = 1'b1;
    end
  end

  // Sticky parity-error flag, cleared together with the range flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         par_err <= 1'b0;
    else if (s1_par_bad || s2_par_bad) par_err <= 1'b1;
    else if (en && err_clr)            par_err <= 1'b0;
  end
`else
  assign par_err = 1'b0;
`endif

endmodule
